// File: rtl/axis_result_serializer_if.sv
// Bus bundle for the result serializer: wide non-stallable result stream in,
// narrow backpressured lane stream out.
interface axis_result_serializer_if #(
  parameter int LANES     = 4,
  parameter int OUT_WIDTH = 16
) ();
  logic [LANES*OUT_WIDTH-1:0] s_axis_tdata;
  logic                       s_axis_tvalid;
  logic                       s_axis_tlast;
  logic [OUT_WIDTH-1:0]       m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       m_axis_tlast;

  // Serializer view: consumes the wide stream, produces the lane stream.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // Environment view: produces the wide stream, consumes the lane stream.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_result_serializer.sv
// Buffers the affine core's untimed result beats in a FIFO and replays each
// beat as EMIT_LANES narrow lanes on a backpressured AXIS master.
module axis_result_serializer #(
  parameter int LANES      = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int EMIT_LANES = 3,
  parameter int DEPTH      = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  axis_result_serializer_if.slave  axis,
  input  logic                     ovf_clear,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (EMIT_LANES > 1) ? $clog2(EMIT_LANES) : 1;
  localparam int DW = LANES * OUT_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(EMIT_LANES - 1);

  // Entry layout: {tlast, lane LANES-1 .. lane 0}
  typedef logic [DW:0] entry_t;

  entry_t               mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [LW-1:0]        lane, lane_next;
  logic                 out_valid, out_last;
  logic [OUT_WIDTH-1:0] out_data;

  logic   fire, pop, wr_en, drop, load_first;
  entry_t head, next_head, in_entry, first_src;

  function automatic logic [OUT_WIDTH-1:0] lane_data(entry_t e, logic [LW-1:0] idx);
    return e[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  assign in_entry  = {axis.s_axis_tlast, axis.s_axis_tdata};
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];
  assign lane_next = lane + LW'(1);

  assign fire  = out_valid & axis.m_axis_tready;
  assign pop   = fire && (lane == LAST_LANE);
  assign wr_en = axis.s_axis_tvalid && ((count < CW'(DEPTH)) || pop);
  assign drop  = axis.s_axis_tvalid && !wr_en;

  // On a pop with only the head stored, the beat being written this same
  // cycle becomes the next head, so it is forwarded to avoid a bubble.
  always_comb begin
    first_src = head;
    if (pop) first_src = (count > CW'(1)) ? next_head : in_entry;
  end

  assign load_first = pop ? ((count > CW'(1)) || wr_en)
                          : (!out_valid && (count != '0));

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      lane      <= '0;
    end else if (fire && !pop) begin
      lane     <= lane_next;
      out_data <= lane_data(head, lane_next);
      out_last <= head[DW] && (lane_next == LAST_LANE);
    end else if (load_first) begin
      out_valid <= 1'b1;
      lane      <= '0;
      out_data  <= lane_data(first_src, '0);
      out_last  <= first_src[DW] && (LAST_LANE == '0);
    end else if (pop) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      lane      <= '0;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (ovf_clear)                  drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (ovf_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tlast  = out_last;
  assign level              = count;
endmodule
